// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU command codes and NZCV bit positions.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_alu_stage_alu_core.sv
// Combinational ARM data-processing ALU: result plus next NZCV.
// Zero latency; unknown commands give result 0 and return the incoming flags.
module alu_core
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [3:0]        status_in,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv
);

    logic              cin;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] op2;
    logic              arith;
    logic              known;

    assign cin = status_in[FLAG_C];

    always_comb begin
        op2    = val2;
        sum    = '0;
        result = '0;
        arith  = 1'b0;
        known  = 1'b1;
        case (cmd)
            CMD_MOV: result = val2;
            CMD_MVN: result = ~val2;
            CMD_ADD: begin
                arith = 1'b1;
                sum   = {1'b0, val1} + {1'b0, op2};
            end
            CMD_ADC: begin
                arith = 1'b1;
                sum   = {1'b0, val1} + {1'b0, op2} + {{DATA_W{1'b0}}, cin};
            end
            // Subtraction is val1 + ~val2 + carry so C comes out as NOT borrow.
            CMD_SUB: begin
                arith = 1'b1;
                op2   = ~val2;
                sum   = {1'b0, val1} + {1'b0, op2} + {{DATA_W{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                arith = 1'b1;
                op2   = ~val2;
                sum   = {1'b0, val1} + {1'b0, op2} + {{DATA_W{1'b0}}, cin};
            end
            CMD_AND: result = val1 & val2;
            CMD_ORR: result = val1 | val2;
            CMD_EOR: result = val1 ^ val2;
            default: known = 1'b0;
        endcase

        if (arith) begin
            result = sum[DATA_W-1:0];
        end

        nzcv = status_in;
        if (known) begin
            nzcv[FLAG_N] = result[DATA_W-1];
            nzcv[FLAG_Z] = (result == '0);
            if (arith) begin
                nzcv[FLAG_C] = sum[DATA_W];
                nzcv[FLAG_V] = (val1[DATA_W-1] == op2[DATA_W-1]) &&
                               (result[DATA_W-1] != val1[DATA_W-1]);
            end
        end
    end

endmodule

// File: rtl/exe_alu_stage.sv
// Execute stage: ALU + NZCV status register + EXE/MEM pipeline registers, latency 1.
// freeze holds every register; flush or !in_valid kills controls and blocks flag update.
module exe_alu_stage
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        exe_cmd,
    input  logic              s_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  dest,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_wb_en,
    output logic [REG_W-1:0]  out_dest,
    output logic [3:0]        status
);

    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_nzcv;
    logic              accept;

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] result_q,   result_d;
    logic [DATA_W-1:0] st_val_q,   st_val_d;
    logic              mem_r_q,    mem_r_d;
    logic              mem_w_q,    mem_w_d;
    logic              wb_q,       wb_d;
    logic [REG_W-1:0]  dest_q,     dest_d;
    logic [3:0]        status_q,   status_d;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .cmd       (exe_cmd),
        .val1      (val1),
        .val2      (val2),
        .status_in (status_q),
        .result    (alu_res),
        .nzcv      (alu_nzcv)
    );

    assign accept = in_valid & ~flush;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        st_val_d = st_val_q;
        mem_r_d  = mem_r_q;
        mem_w_d  = mem_w_q;
        wb_d     = wb_q;
        dest_d   = dest_q;
        status_d = status_q;
        if (!freeze) begin
            valid_d  = accept;
            result_d = alu_res;
            st_val_d = val_rm;
            mem_r_d  = accept & mem_r_en;
            mem_w_d  = accept & mem_w_en;
            wb_d     = accept & wb_en;
            dest_d   = dest;
            if (accept && s_en) begin
                status_d = alu_nzcv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            st_val_q <= '0;
            mem_r_q  <= 1'b0;
            mem_w_q  <= 1'b0;
            wb_q     <= 1'b0;
            dest_q   <= '0;
            status_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            st_val_q <= st_val_d;
            mem_r_q  <= mem_r_d;
            mem_w_q  <= mem_w_d;
            wb_q     <= wb_d;
            dest_q   <= dest_d;
            status_q <= status_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_result   = result_q;
    assign st_val       = st_val_q;
    assign out_mem_r_en = mem_r_q;
    assign out_mem_w_en = mem_w_q;
    assign out_wb_en    = wb_q;
    assign out_dest     = dest_q;
    assign status       = status_q;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage: hand-computed results and NZCV per scenario.
module tb_exe_alu_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, s_en;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en;
    logic [3:0]  dest;
    logic [31:0] val1, val2, val_rm;
    logic        out_valid, out_mem_r_en, out_mem_w_en, out_wb_en;
    logic [31:0] alu_result, st_val;
    logic [3:0]  out_dest, status;

    int checks = 0;
    int errors = 0;

    exe_alu_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .exe_cmd(exe_cmd), .s_en(s_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .dest(dest), .val1(val1), .val2(val2), .val_rm(val_rm),
        .out_valid(out_valid), .alu_result(alu_result), .st_val(st_val),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en),
        .out_dest(out_dest), .status(status)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        exe_cmd  = c;
        val1     = a;
        val2     = b;
        s_en     = s;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; s_en = 1'b0;
        exe_cmd = 4'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0;
        dest = 4'd0; val1 = '0; val2 = '0; val_rm = '0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'h0 || status !== 4'b0000) begin
            errors++;
            $display("FAIL reset: valid=%b result=%h status=%b, expected 0/0/0000",
                     out_valid, alu_result, status);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        wb_en = 1'b1; dest = 4'd3; val_rm = 32'hDEAD_BEEF;
        step();
        checks++;
        if (alu_result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL add_ovf_result: got %h expected 80000000", alu_result);
        end
        checks++;
        if (status !== 4'b1001) begin
            errors++;
            $display("FAIL add_ovf_status: got %b expected 1001", status);
        end
        checks++;
        if (out_valid !== 1'b1 || out_wb_en !== 1'b1 || out_dest !== 4'd3 ||
            st_val !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL add_passthru: valid=%b wb=%b dest=%h st=%h expected 1/1/3/deadbeef",
                     out_valid, out_wb_en, out_dest, st_val);
        end
    endtask

    task automatic test_sub_adc();
        drive(CMD_SUB, 32'd5, 32'd5, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h0 || status !== 4'b0110) begin
            errors++;
            $display("FAIL sub_eq: result=%h status=%b expected 0/0110", alu_result, status);
        end
        drive(CMD_ADC, 32'd1, 32'd2, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd4 || status !== 4'b0000) begin
            errors++;
            $display("FAIL adc_chain: result=%h status=%b expected 4/0000", alu_result, status);
        end
    endtask

    task automatic test_sbc_logic();
        drive(CMD_SBC, 32'd3, 32'd1, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd1 || status !== 4'b0010) begin
            errors++;
            $display("FAIL sbc: result=%h status=%b expected 1/0010", alu_result, status);
        end
        drive(CMD_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h0000_00F0 || status !== 4'b0010) begin
            errors++;
            $display("FAIL and: result=%h status=%b expected 000000f0/0010", alu_result, status);
        end
        drive(CMD_ORR, 32'h0000_0F00, 32'h0000_00F0, 1'b0);
        step();
        checks++;
        if (alu_result !== 32'h0000_0FF0 || status !== 4'b0010) begin
            errors++;
            $display("FAIL orr: result=%h status=%b expected 00000ff0/0010", alu_result, status);
        end
        drive(CMD_EOR, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
        step();
        checks++;
        if (alu_result !== 32'h0000_F0F0) begin
            errors++;
            $display("FAIL eor: got %h expected 0000f0f0", alu_result);
        end
        drive(CMD_MVN, 32'h0, 32'h0, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'hFFFF_FFFF || status !== 4'b1010) begin
            errors++;
            $display("FAIL mvn: result=%h status=%b expected ffffffff/1010", alu_result, status);
        end
        drive(CMD_MOV, 32'h1234, 32'h0, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h0 || status !== 4'b0110) begin
            errors++;
            $display("FAIL mov_zero: result=%h status=%b expected 0/0110", alu_result, status);
        end
        drive(4'b0000, 32'h5, 32'h7, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h0 || status !== 4'b0110) begin
            errors++;
            $display("FAIL bad_cmd: result=%h status=%b expected 0/0110", alu_result, status);
        end
        drive(CMD_SUB, 32'h0, 32'h1, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'hFFFF_FFFF || status !== 4'b1000) begin
            errors++;
            $display("FAIL sub_borrow: result=%h status=%b expected ffffffff/1000",
                     alu_result, status);
        end
        drive(CMD_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h0 || status !== 4'b0110) begin
            errors++;
            $display("FAIL add_carry: result=%h status=%b expected 0/0110", alu_result, status);
        end
    endtask

    task automatic test_load_addr();
        drive(CMD_ADD, 32'h0000_1000, 32'hFFFF_FFFC, 1'b0);
        mem_r_en = 1'b1; wb_en = 1'b1; dest = 4'd9;
        step();
        checks++;
        if (alu_result !== 32'h0000_0FFC || out_mem_r_en !== 1'b1 || status !== 4'b0110) begin
            errors++;
            $display("FAIL load_addr: result=%h mem_r=%b status=%b expected 00000ffc/1/0110",
                     alu_result, out_mem_r_en, status);
        end
        mem_r_en = 1'b0;
    endtask

    task automatic test_freeze();
        drive(CMD_ADD, 32'd1, 32'd1, 1'b1);
        dest = 4'd5;
        step();
        checks++;
        if (alu_result !== 32'd2 || status !== 4'b0000) begin
            errors++;
            $display("FAIL pre_freeze: result=%h status=%b expected 2/0000", alu_result, status);
        end
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(CMD_SUB, 32'h0, 32'(i + 1), 1'b1);
            dest = 4'(10 + i);
            step();
            checks++;
            if (alu_result !== 32'd2 || status !== 4'b0000 || out_dest !== 4'd5) begin
                errors++;
                $display("FAIL freeze_hold%0d: result=%h status=%b dest=%h expected 2/0000/5",
                         i, alu_result, status, out_dest);
            end
        end
        freeze = 1'b0;
        drive(CMD_ADD, 32'd10, 32'd20, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd30 || out_dest !== 4'd12) begin
            errors++;
            $display("FAIL freeze_release: result=%h dest=%h expected 1e/c", alu_result, out_dest);
        end
    endtask

    task automatic test_flush();
        drive(CMD_SUB, 32'd5, 32'd5, 1'b1);
        wb_en = 1'b1; mem_w_en = 1'b1; flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_mem_w_en !== 1'b0 ||
            status !== 4'b0000) begin
            errors++;
            $display("FAIL flush: valid=%b wb=%b mem_w=%b status=%b expected 0/0/0/0000",
                     out_valid, out_wb_en, out_mem_w_en, status);
        end
        flush = 1'b0; mem_w_en = 1'b0;
        drive(CMD_ADD, 32'd3, 32'd4, 1'b0);
        step();
        flush = 1'b1; freeze = 1'b1;
        drive(CMD_SUB, 32'd0, 32'd1, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_wb_en !== 1'b1 || alu_result !== 32'd7 ||
            status !== 4'b0000) begin
            errors++;
            $display("FAIL flush_freeze: valid=%b wb=%b result=%h status=%b expected 1/1/7/0000",
                     out_valid, out_wb_en, alu_result, status);
        end
        flush = 1'b0; freeze = 1'b0;
        drive(CMD_SUB, 32'd0, 32'd1, 1'b1);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || status !== 4'b0000) begin
            errors++;
            $display("FAIL bubble: valid=%b wb=%b status=%b expected 0/0/0000",
                     out_valid, out_wb_en, status);
        end
    endtask

    task automatic test_reset_mid();
        drive(CMD_SUB, 32'd0, 32'd1, 1'b1);
        val_rm = 32'hCAFE_F00D; dest = 4'd6; mem_w_en = 1'b1;
        step();
        checks++;
        if (status !== 4'b1000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: status=%b valid=%b expected 1000/1", status, out_valid);
        end
        drive(CMD_ADD, 32'd8, 32'd9, 1'b1);
        freeze = 1'b1; rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'h0 || st_val !== 32'h0 ||
            out_dest !== 4'd0 || out_wb_en !== 1'b0 || out_mem_w_en !== 1'b0 ||
            out_mem_r_en !== 1'b0 || status !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: valid=%b res=%h st=%h dest=%h wb=%b mw=%b mr=%b st=%b expected all 0",
                     out_valid, alu_result, st_val, out_dest, out_wb_en, out_mem_w_en,
                     out_mem_r_en, status);
        end
        rst = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_adc();
        test_sbc_logic();
        test_load_addr();
        test_freeze();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
